// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one registered W-bit magnitude comparator between NREQ requesters.
// Optional macro CMP_SIGNED_EN adds a per-transaction cmp_signed input for two's-complement compares.
module cmp_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
`ifdef CMP_SIGNED_EN
  input  logic              cmp_signed,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDXW-1:0]   rsp_id,
  output logic              rsp_gt,
  output logic              rsp_lt,
  output logic              rsp_eq,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  logic [1:0]      r_state;
  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] r_id_q;
  logic [W-1:0]    r_a_q;
  logic [W-1:0]    r_b_q;
  logic            r_rsp_valid;
  logic [IDXW-1:0] r_rsp_id;
  logic            r_gt;
  logic            r_lt;
  logic            r_eq;
  logic            r_busy;
`ifdef CMP_SIGNED_EN
  logic            r_sgn_q;
`endif

  logic [IDXW:0]   w_pick;
  logic            w_found;
  logic [IDXW-1:0] w_sel;
  logic            w_grant;
  logic [NREQ-1:0] w_ready;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic            w_gt;
  logic            w_lt;
  logic            w_eq;
  logic [1:0]      w_state_nxt;
  logic [IDXW-1:0] w_ptr_nxt;
  logic            w_rsp_fire;

  // Returns {found, index} of the first asserted request at or after ptr, wrapping.
  function automatic logic [IDXW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDXW-1:0] ptr);
    logic [IDXW:0]   res;
    logic [IDXW-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDXW'((int'(ptr) + k) % NREQ);
      if (v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign w_pick     = rr_pick(req_valid, r_rr_ptr);
  assign w_found    = w_pick[IDXW];
  assign w_sel      = w_pick[IDXW-1:0];
  // Reset also masks the grant so req_ready is quiet while rst_n is low.
  assign w_grant    = rst_n & (r_state == S_IDLE) & w_found;
  assign w_a_sel    = req_a[w_sel*W +: W];
  assign w_b_sel    = req_b[w_sel*W +: W];
  assign w_rsp_fire = r_rsp_valid & rsp_ready;
  assign w_ptr_nxt  = (r_id_q == IDXW'(NREQ - 1)) ? '0 : (r_id_q + IDXW'(1));

  // One-hot accept strobe for the selected requester.
  always_comb begin
    w_ready = '0;
    if (w_grant) begin
      w_ready[w_sel] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  // Comparator on the captured operands.
  always_comb begin
    w_gt = (r_a_q > r_b_q);
    w_lt = (r_a_q < r_b_q);
    w_eq = (r_a_q == r_b_q);
`ifdef CMP_SIGNED_EN
    if (r_sgn_q) begin
      w_gt = ($signed(r_a_q) > $signed(r_b_q));
      w_lt = ($signed(r_a_q) < $signed(r_b_q));
    end else begin
      w_gt = (r_a_q > r_b_q);
      w_lt = (r_a_q < r_b_q);
    end
`endif
  end

  // Next-state selection for IDLE -> CMP -> RSP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_CMP;
        else         w_state_nxt = S_IDLE;
      end
      S_CMP: w_state_nxt = S_RSP;
      S_RSP: begin
        if (w_rsp_fire) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_RSP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, operand capture, registered compare result and pointer advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id_q      <= '0;
      r_a_q       <= '0;
      r_b_q       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_gt        <= 1'b0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_busy      <= 1'b0;
`ifdef CMP_SIGNED_EN
      r_sgn_q     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_a_q  <= w_a_sel;
            r_b_q  <= w_b_sel;
            r_id_q <= w_sel;
`ifdef CMP_SIGNED_EN
            r_sgn_q <= cmp_signed;
`endif
          end
        end
        S_CMP: begin
          r_gt        <= w_gt;
          r_lt        <= w_lt;
          r_eq        <= w_eq;
          r_rsp_id    <= r_id_q;
          r_rsp_valid <= 1'b1;
        end
        S_RSP: begin
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq        <= 1'b0;
            r_rr_ptr    <= w_ptr_nxt;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_gt        <= 1'b0;
          r_lt        <= 1'b0;
          r_eq        <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_gt    = r_gt;
  assign rsp_lt    = r_lt;
  assign rsp_eq    = r_eq;
  assign busy      = r_busy;

endmodule

// File: tb/tb_cmp_share_arb.sv
// Self-checking bench for cmp_share_arb: directed scenarios plus randomized traffic against a
// transaction-level reference (round-robin pick, fixed 2-cycle latency, arithmetic compare).
module tb_cmp_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDXW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDXW-1:0]   rsp_id;
  logic              rsp_gt;
  logic              rsp_lt;
  logic              rsp_eq;
  logic              rsp_ready;
  logic              busy;
  logic              sgn_s = 1'b0;

  cmp_share_arb #(.NREQ(NREQ), .W(W), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef CMP_SIGNED_EN
    .cmp_signed(sgn_s),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // requester-side state
  bit         pend [NREQ];
  logic [W-1:0] ta [NREQ];
  logic [W-1:0] tbv[NREQ];

  // reference model: at most one outstanding transaction
  bit       m_out;
  int       m_age;
  int       m_id;
  int       m_ptr;
  logic [2:0] m_flags;
  int       cyc;
  int       grant_idx[$];
  int       grant_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_flags(input int a, input int b, input bit s);
    int sa, sb;
    sa = a;
    sb = b;
    if (s) begin
      if (sa >= (1 << (W - 1))) sa = sa - (1 << W);
      if (sb >= (1 << (W - 1))) sb = sb - (1 << W);
    end
    return {sa > sb, sa < sb, sa == sb};
  endfunction

  task automatic apply_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]     = pend[i];
      req_a[i*W +: W]  = ta[i];
      req_b[i*W +: W]  = tbv[i];
    end
  endtask

  task automatic model_reset();
    m_out = 1'b0;
    m_age = 0;
    m_id  = 0;
    m_ptr = 0;
  endtask

  // Called just after a falling edge with inputs already applied; checks, then advances one cycle.
  task automatic run_cycle();
    int sel;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] obs_ready;
    bit fire;
    #1;
    sel = -1;
    exp_ready = '0;
    if (!m_out) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (req_valid[idx] && sel < 0) sel = idx;
      end
    end
    if (sel >= 0) exp_ready[sel] = 1'b1;
    obs_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_out));
    check("rsp_valid", 32'(rsp_valid), 32'(m_out && m_age >= 2));
    if (m_out && m_age >= 2) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'(m_flags));
    end else begin
      check("flags_idle", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h0);
    end
    fire = m_out && (m_age >= 2) && rsp_ready;
    if (obs_ready != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (obs_ready[i]) begin
          grant_idx.push_back(i);
          grant_cyc.push_back(cyc);
        end
      end
    end
    if (sel >= 0) begin
      m_out   = 1'b1;
      m_age   = 1;
      m_id    = sel;
      m_flags = ref_flags(int'(req_a[sel*W +: W]), int'(req_b[sel*W +: W]), sgn_s);
    end else if (m_out) begin
      if (fire) begin
        m_out = 1'b0;
        m_ptr = (m_id + 1) % NREQ;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    for (int i = 0; i < NREQ; i++) if (obs_ready[i]) pend[i] = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_random();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ta[i]   = W'($urandom);
          tbv[i]  = ($urandom_range(0, 3) == 0) ? ta[i] : W'($urandom);
        end
      end else if ($urandom_range(0, 40) == 0) begin
        pend[i] = 1'b0;
      end
    end
    apply_reqs();
    rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef CMP_SIGNED_EN
    sgn_s = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
    check({tag, "_flags"}, 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    int start;
    cyc = 0;
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      ta[i]   = '0;
      tbv[i]  = '0;
    end
    rst_n = 1'b0;

    // reset with random inputs: every output quiet
    repeat (3) begin
      req_valid = NREQ'($urandom);
      req_a     = (NREQ*W)'($urandom);
      req_b     = (NREQ*W)'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      check_all_zero("rst");
    end

    // release; first grant is the lowest asserted index from 0
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    pend[1] = 1'b1; ta[1] = 8'h10; tbv[1] = 8'h20;
    pend[3] = 1'b1; ta[3] = 8'h33; tbv[3] = 8'h33;
    apply_reqs();
    #1;
    check("first_grant", 32'(req_ready), 32'h2);
    run_cycle();
    repeat (6) begin apply_reqs(); run_cycle(); end

    // single requester 2: 0x80 vs 0x7F
    pend[2] = 1'b1; ta[2] = 8'h80; tbv[2] = 8'h7F;
    apply_reqs();
    #1;
    check("t2_grant", 32'(req_ready), 32'h4);
    run_cycle();
    apply_reqs(); run_cycle();
    apply_reqs();
    #1;
    check("t2_valid", 32'(rsp_valid), 32'h1);
    check("t2_id", 32'(rsp_id), 32'h2);
    check("t2_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h4);
    run_cycle();
    apply_reqs(); run_cycle();

    // all four requesting continuously: rotation and 3-cycle spacing
    for (int i = 0; i < NREQ; i++) begin
      ta[i]  = W'($urandom);
      tbv[i] = W'($urandom);
    end
    grant_idx.delete();
    grant_cyc.delete();
    start = m_ptr;
    repeat (15) begin
      for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
      apply_reqs();
      run_cycle();
    end
    check("rot_count", 32'(grant_idx.size()), 32'd5);
    for (int k = 0; k < grant_idx.size() && k < 5; k++) begin
      check("rot_order", 32'(grant_idx[k]), 32'((start + k) % NREQ));
      if (k > 0) check("rot_spacing", 32'(grant_cyc[k] - grant_cyc[k-1]), 32'd3);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    apply_reqs();
    rsp_ready = 1'b1;
    repeat (3) begin apply_reqs(); run_cycle(); end

    // held response with back-pressure while another requester waits
    pend[1] = 1'b1; ta[1] = 8'h5A; tbv[1] = 8'h5A;
    rsp_ready = 1'b0;
    apply_reqs();
    while (pend[1]) begin
      run_cycle();
      apply_reqs();
    end
    run_cycle();
    pend[0] = 1'b1; ta[0] = 8'h01; tbv[0] = 8'h02;
    repeat (5) begin
      apply_reqs();
      #1;
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_eq", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h1);
      check("hold_busy", 32'(busy), 32'h1);
      check("hold_noready", 32'(req_ready), 32'h0);
      run_cycle();
    end
    rsp_ready = 1'b1;
    apply_reqs();
    run_cycle();
    apply_reqs();
    #1;
    check("drain_valid", 32'(rsp_valid), 32'h0);
    check("drain_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h0);
    run_cycle();
    repeat (4) begin apply_reqs(); run_cycle(); end

    // asynchronous reset while a response is pending
    pend[3] = 1'b1; ta[3] = 8'hC0; tbv[3] = 8'h0C;
    rsp_ready = 1'b0;
    repeat (3) begin apply_reqs(); run_cycle(); end
    pend[2] = 1'b1; ta[2] = 8'h07; tbv[2] = 8'h70;
    apply_reqs();
    #1;
    check("pre_rst_valid", 32'(rsp_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rsp_ready = 1'b1;
    #1;
    check("post_rst_valid", 32'(rsp_valid), 32'h0);
    check("post_rst_busy", 32'(busy), 32'h0);
    run_cycle();
    repeat (4) begin apply_reqs(); run_cycle(); end

`ifdef CMP_SIGNED_EN
    // signed versus unsigned view of 0x80 vs 0x01
    pend[0] = 1'b1; ta[0] = 8'h80; tbv[0] = 8'h01;
    sgn_s = 1'b1;
    apply_reqs(); run_cycle();
    sgn_s = 1'b0;
    apply_reqs(); run_cycle();
    apply_reqs();
    #1;
    check("signed_lt", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h2);
    run_cycle();
    pend[0] = 1'b1;
    sgn_s = 1'b0;
    apply_reqs(); run_cycle();
    apply_reqs(); run_cycle();
    apply_reqs();
    #1;
    check("unsigned_gt", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'h4);
    run_cycle();
    apply_reqs(); run_cycle();
`endif

    // randomized traffic
    repeat (1500) begin
      drive_random();
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
